// File: rtl/fast_top_level.sv
// -----------------------------------------------------------------------------
// fast_top_level
//
// Corner-detection stage of the ISP pipeline. Gaussian-filtered pixels arrive
// in the upstream image SRAM (SRAM2) in raster order. This block counts them as
// they are reported written. Once the three rows around the current row are
// present, it reads each interior pixel and its 8-pixel ring. It then runs a
// FAST-style contiguity test and strobes the coordinates of every corner out
// to the corner SRAM (SRAM4). Because rows are processed as soon as their
// neighbourhood exists, this stage overlaps with the Gaussian stage.
//
// Ports
//   clk, n_rst          clock, asynchronous active-low reset
//   new_trans           one-cycle pulse: start (or restart) a frame
//   max_x, max_y        runtime image width / height in pixels
//   gaus_sample_flag    one-cycle pulse: one more pixel is now in SRAM2
//   SRAM_in             SRAM2 read data (valid the cycle after a read)
//   read_SRAM2          SRAM2 read enable
//   x_addr, y_addr      SRAM2 read address (held when not reading)
//   write_SRAM4         one-cycle corner write strobe
//   x_addr4, y_addr4    corner coordinates, valid while write_SRAM4 is high
//   gaus_done           one-cycle pulse: frame fully processed
// -----------------------------------------------------------------------------
module fast_top_level #(
    parameter int X_MAX     = 5,
    parameter int Y_MAX     = 5,
    parameter int THRESHOLD = 20
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     new_trans,
    input  logic [$clog2(X_MAX)-1:0] max_x,
    input  logic [$clog2(X_MAX)-1:0] max_y,
    input  logic                     gaus_sample_flag,
    input  logic [7:0]               SRAM_in,
    output logic                     read_SRAM2,
    output logic [$clog2(X_MAX):0]   x_addr,
    output logic [$clog2(X_MAX):0]   y_addr,
    output logic                     write_SRAM4,
    output logic [$clog2(X_MAX):0]   x_addr4,
    output logic [$clog2(X_MAX):0]   y_addr4,
    output logic                     gaus_done
);

    localparam int AW      = $clog2(X_MAX);
    localparam int CW      = AW + 1;
    localparam int DIM_MAX = (X_MAX > Y_MAX) ? X_MAX : Y_MAX;
    // Wide enough for (row+2)*max_x and max_x*max_y at any runtime size.
    localparam int VW      = 2 * ($clog2(DIM_MAX) + 1);

    localparam logic [8:0]    THR = 9'(THRESHOLD);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROW,
        READ,
        EVAL,
        WRITE,
        NEXT
    } state_t;

    state_t        state_reg;
    logic [VW-1:0] avail_reg;
    logic [CW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic [3:0]    idx_reg;          // 0..8 issue reads, 9 is the final capture
    logic [7:0]    pix_reg [0:8];    // [0] centre, [1..8] ring positions 0..7

    logic [CW-1:0] width;
    logic [CW-1:0] height;
    logic [VW-1:0] frame_size;
    logic [VW-1:0] row_need;
    logic          degenerate;

    assign width      = CW'(max_x);
    assign height     = CW'(max_y);
    assign frame_size = VW'(max_x) * VW'(max_y);
    // Rows row-1..row+1 are complete once (row+2) full rows have been written.
    assign row_need   = (VW'(row_reg) + VW'(2)) * VW'(max_x);
    assign degenerate = (max_x < AW'(3)) || (max_y < AW'(3));

    // ---------------------------------------------------------------------
    // Bright / dark classification of the ring and 5-long circular run test
    // ---------------------------------------------------------------------
    logic [7:0] bright;
    logic [7:0] dark;
    logic [7:0] bright_run;
    logic [7:0] dark_run;
    logic       corner;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_class
            assign bright[gi] = {1'b0, pix_reg[gi+1]} > ({1'b0, pix_reg[0]} + THR);
            assign dark[gi]   = ({1'b0, pix_reg[gi+1]} + THR) < {1'b0, pix_reg[0]};
        end
        // Run starting at ring position gi; indices wrap from 7 back to 0.
        for (genvar gi = 0; gi < 8; gi++) begin : g_run
            assign bright_run[gi] = bright[gi]           & bright[(gi + 1) % 8] &
                                    bright[(gi + 2) % 8] & bright[(gi + 3) % 8] &
                                    bright[(gi + 4) % 8];
            assign dark_run[gi]   = dark[gi]             & dark[(gi + 1) % 8] &
                                    dark[(gi + 2) % 8]   & dark[(gi + 3) % 8] &
                                    dark[(gi + 4) % 8];
        end
    endgenerate

    assign corner = (|bright_run) || (|dark_run);

    // Address of read k for the pixel at (c, r): k=0 centre, k=1..8 the ring
    // clockwise from the top-left neighbour.
    function automatic logic [2*CW-1:0] tap_addr(input logic [3:0]    k,
                                                 input logic [CW-1:0] c,
                                                 input logic [CW-1:0] r);
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        x = c;
        y = r;
        case (k)
            4'd1: begin x = c - ONE; y = r - ONE; end
            4'd2: begin x = c;       y = r - ONE; end
            4'd3: begin x = c + ONE; y = r - ONE; end
            4'd4: begin x = c + ONE; y = r;       end
            4'd5: begin x = c + ONE; y = r + ONE; end
            4'd6: begin x = c;       y = r + ONE; end
            4'd7: begin x = c - ONE; y = r + ONE; end
            4'd8: begin x = c - ONE; y = r;       end
            default: begin x = c;    y = r;       end
        endcase
        return {x, y};
    endfunction

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg   <= IDLE;
            avail_reg   <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            idx_reg     <= '0;
            for (int i = 0; i < 9; i++) begin
                pix_reg[i] <= '0;
            end
            read_SRAM2  <= 1'b0;
            x_addr      <= '0;
            y_addr      <= '0;
            write_SRAM4 <= 1'b0;
            x_addr4     <= '0;
            y_addr4     <= '0;
            gaus_done   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state explicitly re-asserts them.
            read_SRAM2  <= 1'b0;
            write_SRAM4 <= 1'b0;
            gaus_done   <= 1'b0;

            if (new_trans) begin
                // Start or abort: any sample arriving this cycle is dropped.
                state_reg <= WAIT_ROW;
                avail_reg <= '0;
                row_reg   <= ONE;
                col_reg   <= ONE;
                idx_reg   <= '0;
            end else begin
                if (gaus_sample_flag && (state_reg != IDLE) && (avail_reg < frame_size)) begin
                    avail_reg <= avail_reg + VW'(1);
                end

                case (state_reg)
                    IDLE: begin
                    end

                    WAIT_ROW: begin
                        if (degenerate) begin
                            gaus_done <= 1'b1;
                            state_reg <= IDLE;
                        end else if (avail_reg >= row_need) begin
                            state_reg        <= READ;
                            idx_reg          <= '0;
                            read_SRAM2       <= 1'b1;
                            {x_addr, y_addr} <= tap_addr(4'd0, col_reg, row_reg);
                        end
                    end

                    READ: begin
                        // Data for the read issued last cycle is on SRAM_in now.
                        if (idx_reg != 4'd0) begin
                            pix_reg[idx_reg - 4'd1] <= SRAM_in;
                        end
                        if (idx_reg < 4'd8) begin
                            read_SRAM2       <= 1'b1;
                            {x_addr, y_addr} <= tap_addr(idx_reg + 4'd1, col_reg, row_reg);
                        end
                        if (idx_reg == 4'd9) begin
                            state_reg <= EVAL;
                        end else begin
                            idx_reg <= idx_reg + 4'd1;
                        end
                    end

                    EVAL: begin
                        if (corner) begin
                            write_SRAM4 <= 1'b1;
                            x_addr4     <= col_reg;
                            y_addr4     <= row_reg;
                            state_reg   <= WRITE;
                        end else begin
                            state_reg <= NEXT;
                        end
                    end

                    WRITE: begin
                        state_reg <= NEXT;
                    end

                    NEXT: begin
                        if (col_reg == width - CW'(2)) begin
                            col_reg <= ONE;
                            if (row_reg + ONE > height - CW'(2)) begin
                                gaus_done <= 1'b1;
                                state_reg <= IDLE;
                            end else begin
                                row_reg   <= row_reg + ONE;
                                state_reg <= WAIT_ROW;
                            end
                        end else begin
                            // Same row: its neighbourhood is already present.
                            col_reg          <= col_reg + ONE;
                            state_reg        <= READ;
                            idx_reg          <= '0;
                            read_SRAM2       <= 1'b1;
                            {x_addr, y_addr} <= tap_addr(4'd0, col_reg + ONE, row_reg);
                        end
                    end

                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fast_top_level.sv
// -----------------------------------------------------------------------------
// tb_fast_top_level
//
// Bench for fast_top_level. A behavioural SRAM2 model serves reads from an
// image array. A negedge monitor records every read address, every corner
// write and every gaus_done pulse. A reference model computes, straight from
// the image, the expected read sequence and the expected corner list for a
// frame. Each scenario task drives its own stimulus and makes its own
// comparisons.
// -----------------------------------------------------------------------------
module tb_fast_top_level;

    localparam int X_MAX     = 5;
    localparam int THRESHOLD = 20;
    localparam int AW        = $clog2(X_MAX);
    localparam int CW        = AW + 1;

    logic          clk              = 1'b0;
    logic          n_rst            = 1'b1;
    logic          new_trans        = 1'b0;
    logic [AW-1:0] max_x            = '0;
    logic [AW-1:0] max_y            = '0;
    logic          gaus_sample_flag = 1'b0;
    logic [7:0]    SRAM_in          = '0;
    logic          read_SRAM2;
    logic [CW-1:0] x_addr;
    logic [CW-1:0] y_addr;
    logic          write_SRAM4;
    logic [CW-1:0] x_addr4;
    logic [CW-1:0] y_addr4;
    logic          gaus_done;

    fast_top_level #(
        .X_MAX     (X_MAX),
        .Y_MAX     (5),
        .THRESHOLD (THRESHOLD)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .new_trans        (new_trans),
        .max_x            (max_x),
        .max_y            (max_y),
        .gaus_sample_flag (gaus_sample_flag),
        .SRAM_in          (SRAM_in),
        .read_SRAM2       (read_SRAM2),
        .x_addr           (x_addr),
        .y_addr           (y_addr),
        .write_SRAM4      (write_SRAM4),
        .x_addr4          (x_addr4),
        .y_addr4          (y_addr4),
        .gaus_done        (gaus_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Image held in SRAM2, indexed [y][x]. Read data is valid the cycle after.
    logic [7:0] img [0:15][0:15];
    always @(posedge clk) begin
        if (read_SRAM2 === 1'b1) SRAM_in <= img[y_addr][x_addr];
    end

    // Monitor: addresses are encoded as y*16 + x.
    int rd_q[$];
    int wr_q[$];
    int done_cnt  = 0;
    int sent_cnt  = 0;
    int gate_viol = 0;
    int cur_w     = 5;

    always @(negedge clk) begin
        if (read_SRAM2 === 1'b1) begin
            rd_q.push_back(int'(y_addr) * 16 + int'(x_addr));
            // Any pixel read must already have been reported written.
            if (sent_cnt < (int'(y_addr) + 1) * cur_w) gate_viol++;
        end
        if (write_SRAM4 === 1'b1) wr_q.push_back(int'(y_addr4) * 16 + int'(x_addr4));
        if (gaus_done === 1'b1) done_cnt++;
    end

    // Reference model
    int exp_rd[$];
    int exp_wr[$];
    int dx [0:7] = '{-1, 0, 1, 1, 1, 0, -1, -1};
    int dy [0:7] = '{-1, -1, -1, 0, 1, 1, 1, 0};

    function automatic void build_model(input int w, input int h);
        int  cv;
        int  p;
        bit  b [0:7];
        bit  d [0:7];
        bit  hit;
        bit  allb;
        bit  alld;
        exp_rd.delete();
        exp_wr.delete();
        if (w < 3 || h < 3) return;
        for (int r = 1; r <= h - 2; r++) begin
            for (int c = 1; c <= w - 2; c++) begin
                cv = int'(img[r][c]);
                exp_rd.push_back(r * 16 + c);
                for (int n = 0; n < 8; n++) begin
                    p = int'(img[r + dy[n]][c + dx[n]]);
                    exp_rd.push_back((r + dy[n]) * 16 + (c + dx[n]));
                    b[n] = (p > cv + THRESHOLD);
                    d[n] = (p + THRESHOLD < cv);
                end
                hit = 1'b0;
                for (int s = 0; s < 8; s++) begin
                    allb = 1'b1;
                    alld = 1'b1;
                    for (int j = 0; j < 5; j++) begin
                        allb = allb & b[(s + j) % 8];
                        alld = alld & d[(s + j) % 8];
                    end
                    if (allb || alld) hit = 1'b1;
                end
                if (hit) exp_wr.push_back(r * 16 + c);
            end
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = 8'(v);
    endtask

    task automatic random_image(input int mode);
        int bg;
        bg = int'($urandom_range(200, 30));
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                if (mode == 0) img[y][x] = 8'($urandom_range(255, 0));
                else if ($urandom_range(5, 0) == 0) img[y][x] = 8'($urandom_range(255, 0));
                else img[y][x] = 8'(bg + int'($urandom_range(4, 0)));
            end
        end
    endtask

    task automatic start_frame(input int w, input int h);
        max_x     = AW'(w);
        max_y     = AW'(h);
        cur_w     = w;
        new_trans = 1'b1;
        tick(1);
        new_trans = 1'b0;
        rd_q.delete();
        wr_q.delete();
        done_cnt  = 0;
        sent_cnt  = 0;
        gate_viol = 0;
    endtask

    task automatic feed(input int count, input int gap_max);
        for (int i = 0; i < count; i++) begin
            gaus_sample_flag = 1'b1;
            sent_cnt++;
            tick(1);
            gaus_sample_flag = 1'b0;
            tick(int'($urandom_range(gap_max, 0)));
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL %s done_timeout: got no gaus_done within %0d cycles, required one", name, budget);
        end
        tick(3);
    endtask

    task automatic check_frame(input string name);
        int bad;
        checks++;
        if (rd_q.size() !== exp_rd.size()) begin
            failures++;
            $display("FAIL %s read_count: got %0d required %0d", name, rd_q.size(), exp_rd.size());
        end
        bad = 0;
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
            if (rd_q[i] !== exp_rd[i]) bad++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s read_order: got %0d wrong addresses required 0", name, bad);
        end
        checks++;
        if (wr_q.size() !== exp_wr.size()) begin
            failures++;
            $display("FAIL %s corner_count: got %0d required %0d", name, wr_q.size(), exp_wr.size());
        end
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
            if (wr_q[i] !== exp_wr[i]) bad++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s corner_coords: got %0d wrong coordinates required 0", name, bad);
        end
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d required 1", name, done_cnt);
        end
        checks++;
        if (gate_viol !== 0) begin
            failures++;
            $display("FAIL %s early_read: got %0d reads of unwritten rows required 0", name, gate_viol);
        end
        $display("frame %s %0dx%0d reads=%0d corners=%0d done=%0d", name, cur_w, int'(max_y),
                 rd_q.size(), wr_q.size(), done_cnt);
    endtask

    task automatic run_frame(input string name, input int w, input int h,
                             input int gap_max, input int extra);
        build_model(w, h);
        start_frame(w, h);
        feed(w * h + extra, gap_max);
        wait_done(name, 30 * w * h + 50);
        check_frame(name);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        #2 n_rst = 1'b0;
        tick(2);
        checks++;
        if ({read_SRAM2, write_SRAM4, gaus_done, x_addr, y_addr, x_addr4, y_addr4} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0",
                     {read_SRAM2, write_SRAM4, gaus_done, x_addr, y_addr, x_addr4, y_addr4});
        end
        n_rst = 1'b1;
        tick(5);
        checks++;
        if ({read_SRAM2, write_SRAM4, gaus_done, x_addr, y_addr, x_addr4, y_addr4} !== '0) begin
            failures++;
            $display("FAIL idle_outputs: got %h required 0",
                     {read_SRAM2, write_SRAM4, gaus_done, x_addr, y_addr, x_addr4, y_addr4});
        end
        max_x = AW'(5);
        max_y = AW'(5);
        feed(20, 0);
        tick(10);
        checks++;
        if (rd_q.size() !== 0 || done_cnt !== 0) begin
            failures++;
            $display("FAIL idle_samples: got reads=%0d done=%0d required 0 and 0", rd_q.size(), done_cnt);
        end
        $display("reset/idle: reads=%0d", rd_q.size());
    endtask

    task automatic test_uniform();
        fill(8'h40);
        run_frame("uniform", 5, 5, 1, 0);
        checks++;
        if (rd_q.size() !== 81 || wr_q.size() !== 0) begin
            failures++;
            $display("FAIL uniform_totals: got reads=%0d writes=%0d required 81 and 0", rd_q.size(), wr_q.size());
        end
    endtask

    task automatic test_single_peak();
        fill(10);
        img[2][2] = 8'd200;
        run_frame("peak", 5, 5, 2, 0);
        checks++;
        if (wr_q.size() !== 1 || (wr_q.size() == 1 && wr_q[0] !== 2 * 16 + 2)) begin
            failures++;
            $display("FAIL peak_corner: got %0d writes first=%0d required 1 write at 34",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : -1);
        end
    endtask

    task automatic test_row_gating();
        int n;
        int first;
        random_image(1);
        build_model(5, 5);
        start_frame(5, 5);
        feed(14, 1);
        tick(20);
        checks++;
        if (rd_q.size() !== 0) begin
            failures++;
            $display("FAIL gate_14_samples: got %0d reads required 0", rd_q.size());
        end
        feed(1, 0);
        n = 0;
        while (rd_q.size() == 0 && n < 10) begin
            tick(1);
            n++;
        end
        first = (rd_q.size() > 0) ? rd_q[0] : -1;
        checks++;
        if (first !== 1 * 16 + 1) begin
            failures++;
            $display("FAIL gate_first_read: got address %0d required 17", first);
        end
        feed(10, 1);
        wait_done("row_gating", 800);
        check_frame("row_gating");
    endtask

    task automatic test_threshold();
        int ring_v [0:3] = '{120, 121, 80, 79};
        int want   [0:3] = '{0, 1, 0, 1};
        string nm;
        for (int k = 0; k < 4; k++) begin
            fill(ring_v[k]);
            img[1][1] = 8'd100;
            nm = $sformatf("thresh_%0d", ring_v[k]);
            run_frame(nm, 3, 3, 0, 0);
            checks++;
            if (wr_q.size() !== want[k] || (want[k] == 1 && wr_q.size() == 1 && wr_q[0] !== 17)) begin
                failures++;
                $display("FAIL %s corner: got %0d writes required %0d at 17", nm, wr_q.size(), want[k]);
            end
        end
    endtask

    task automatic test_abort();
        int n;
        random_image(0);
        build_model(5, 5);
        start_frame(5, 5);
        feed(15, 0);
        n = 0;
        while (rd_q.size() < 3 && n < 20) begin
            tick(1);
            n++;
        end
        start_frame(5, 5);
        checks++;
        if (read_SRAM2 !== 1'b0 || write_SRAM4 !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs: got read=%b write=%b required 0 0", read_SRAM2, write_SRAM4);
        end
        tick(30);
        checks++;
        if (rd_q.size() !== 0) begin
            failures++;
            $display("FAIL abort_no_reads: got %0d reads required 0", rd_q.size());
        end
        checks++;
        if (done_cnt !== 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt);
        end
        feed(25, 1);
        wait_done("abort_rerun", 800);
        check_frame("abort_rerun");
    endtask

    task automatic test_degenerate();
        int shapes_w [0:1] = '{2, 5};
        int shapes_h [0:1] = '{5, 2};
        int n;
        for (int k = 0; k < 2; k++) begin
            random_image(0);
            start_frame(shapes_w[k], shapes_h[k]);
            n = 0;
            while (done_cnt == 0 && n < 4) begin
                tick(1);
                n++;
            end
            checks++;
            if (done_cnt !== 1) begin
                failures++;
                $display("FAIL degenerate_%0d done_prompt: got %0d pulses within 4 cycles required 1", k, done_cnt);
            end
            feed(10, 0);
            tick(5);
            checks++;
            if (rd_q.size() !== 0 || wr_q.size() !== 0 || done_cnt !== 1) begin
                failures++;
                $display("FAIL degenerate_%0d quiet: got reads=%0d writes=%0d done=%0d required 0 0 1",
                         k, rd_q.size(), wr_q.size(), done_cnt);
            end
            $display("frame degenerate_%0d %0dx%0d reads=%0d done=%0d", k, shapes_w[k], shapes_h[k],
                     rd_q.size(), done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int h;
        for (int k = 0; k < 6; k++) begin
            w = int'($urandom_range(5, 3));
            h = int'($urandom_range(5, 3));
            random_image(k % 2);
            run_frame($sformatf("random_%0d", k), w, h, int'($urandom_range(3, 0)),
                      int'($urandom_range(4, 0)));
        end
    endtask

    initial begin
        fill(0);
        test_reset();
        test_uniform();
        test_single_peak();
        test_row_gating();
        test_threshold();
        test_abort();
        test_degenerate();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
